// File: rtl/cnn_stream_mem.sv
// cnn_stream_mem: on-chip word memory for the CNN accelerator.
//
// The host reaches the RAM and a small control register file through a
// chipselect/read/write port. A stream engine bursts LEN words starting at
// BASE, wrapping at DEPTH, to the compute datapath over valid/ready. After
// reset, or on a CLEAR command, a sequential engine zeroes one word per
// cycle.
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   chipselect/write/read host access qualifier and strobes
//   address               MSB=0 RAM word, MSB=1 register (0 CTRL, 1 BASE, 2 LEN, 3 STATUS)
//   writedata             host write data
//   val_out, val_valid    registered host read data and its one-cycle pulse
//   stream_data/valid/last/ready  burst output, valid/ready handshake
//   busy                  engine not idle
module cnn_stream_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W:0]   address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] val_out,
  output logic              val_valid,
  output logic [DATA_W-1:0] stream_data,
  output logic              stream_valid,
  output logic              stream_last,
  input  logic              stream_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] clr_idx_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] rd_idx_r;
  logic [ADDR_W:0]   rem_r;
  logic              done_r;
  logic              busy_r;

  // Two-slot buffer: out_* drives the stream port, skid_* holds the overflow.
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_valid_r;
  logic              skid_last_r;

  logic [DATA_W-1:0] val_out_r;
  logic              val_valid_r;

  logic              host_wr_s;
  logic              host_rd_s;
  logic              ram_sel_s;
  logic [1:0]        reg_sel_s;
  logic              ctrl_wr_s;
  logic              start_cmd_s;
  logic              clear_cmd_s;
  logic              ack_cmd_s;
  logic              pop_s;
  logic              issue_s;
  logic              issue_last_s;
  logic [ADDR_W:0]   len_wr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] reg_rdata_s;

  // Host port decode and stream issue decision.
  always_comb begin
    host_wr_s    = chipselect & write & ~reset;
    host_rd_s    = chipselect & read;
    ram_sel_s    = ~address[ADDR_W];
    reg_sel_s    = address[1:0];
    ctrl_wr_s    = host_wr_s & ~ram_sel_s & (reg_sel_s == 2'd0);
    // CLEAR takes precedence over START when both bits are written together.
    clear_cmd_s  = ctrl_wr_s & writedata[1];
    start_cmd_s  = ctrl_wr_s & writedata[0] & ~writedata[1];
    ack_cmd_s    = ctrl_wr_s & writedata[2];
    len_wr_s     = writedata[ADDR_W:0];
    pop_s        = out_valid_r & stream_ready;
    // Only read when a slot is guaranteed free as the data lands next edge.
    issue_s      = (state_r == S_STREAM) & (~skid_valid_r | pop_s);
    issue_last_s = (rem_r == (ADDR_W+1)'(1'b1));
  end

  // Single RAM write port: the clear engine owns it during CLEAR.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = address[ADDR_W-1:0];
    mem_wdata_s = writedata;
    if (state_r == S_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_idx_r;
      mem_wdata_s = '0;
    end else if (host_wr_s & ram_sel_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Register-file read mux (CTRL reads as zero).
  always_comb begin
    reg_rdata_s = '0;
    case (reg_sel_s)
      2'd0:    reg_rdata_s = '0;
      2'd1:    reg_rdata_s = DATA_W'(base_r);
      2'd2:    reg_rdata_s = DATA_W'(len_r);
      2'd3:    reg_rdata_s = DATA_W'({done_r, (state_r == S_CLEAR),
                                      ((state_r == S_STREAM) | (state_r == S_DRAIN))});
      default: reg_rdata_s = '0;
    endcase
  end

  // RAM array write; reads elsewhere see the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control registers, clear sequencer, stream sequencer and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_CLEAR;
      busy_r    <= 1'b1;
      clr_idx_r <= '0;
      base_r    <= '0;
      len_r     <= '0;
      rd_idx_r  <= '0;
      rem_r     <= '0;
      done_r    <= 1'b0;
    end else begin
      if (host_wr_s & ~ram_sel_s & (reg_sel_s == 2'd1)) begin
        base_r <= writedata[ADDR_W-1:0];
      end
      if (host_wr_s & ~ram_sel_s & (reg_sel_s == 2'd2)) begin
        if (len_wr_s > (ADDR_W+1)'(DEPTH)) begin
          len_r <= (ADDR_W+1)'(DEPTH);
        end else begin
          len_r <= len_wr_s;
        end
      end
      // Acknowledge first so any set below in the same cycle wins.
      if (ack_cmd_s) begin
        done_r <= 1'b0;
      end
      case (state_r)
        S_CLEAR: begin
          clr_idx_r <= clr_idx_r + ADDR_W'(1'b1);
          if (clr_idx_r == ADDR_W'(DEPTH - 1)) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clear_cmd_s) begin
            state_r   <= S_CLEAR;
            busy_r    <= 1'b1;
            clr_idx_r <= '0;
            done_r    <= 1'b0;
          end else if (start_cmd_s) begin
            if (len_r == '0) begin
              done_r <= 1'b1;
            end else begin
              state_r  <= S_STREAM;
              busy_r   <= 1'b1;
              rd_idx_r <= base_r;
              rem_r    <= len_r;
              done_r   <= 1'b0;
            end
          end
        end
        S_STREAM: begin
          if (issue_s) begin
            rd_idx_r <= rd_idx_r + ADDR_W'(1'b1);
            rem_r    <= rem_r - (ADDR_W+1)'(1'b1);
            if (issue_last_s) begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop_s & out_last_r) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_CLEAR;
          busy_r    <= 1'b1;
          clr_idx_r <= '0;
        end
      endcase
    end
  end

  // Skid buffer: RAM read data lands in the head slot if it is free or
  // draining, otherwise in the skid slot; the head never changes while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
    end else if (out_valid_r & ~pop_s) begin
      if (issue_s) begin
        skid_data_r  <= mem_r[rd_idx_r];
        skid_last_r  <= issue_last_s;
        skid_valid_r <= 1'b1;
      end
    end else if (skid_valid_r) begin
      out_data_r  <= skid_data_r;
      out_last_r  <= skid_last_r;
      out_valid_r <= 1'b1;
      if (issue_s) begin
        skid_data_r <= mem_r[rd_idx_r];
        skid_last_r <= issue_last_s;
      end else begin
        skid_valid_r <= 1'b0;
      end
    end else if (issue_s) begin
      out_data_r  <= mem_r[rd_idx_r];
      out_last_r  <= issue_last_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  // Host read data register; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_out_r   <= '0;
      val_valid_r <= 1'b0;
    end else begin
      val_valid_r <= host_rd_s;
      if (host_rd_s) begin
        val_out_r <= ram_sel_s ? mem_r[address[ADDR_W-1:0]] : reg_rdata_s;
      end
    end
  end

  assign val_out      = val_out_r;
  assign val_valid    = val_valid_r;
  assign stream_data  = out_data_r;
  assign stream_valid = out_valid_r;
  assign stream_last  = out_last_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_cnn_stream_mem.sv
// Self-checking bench for cnn_stream_mem: a register/RAM vector table, burst
// runs compared against an array model of the memory, and hand-written
// sequences for clear, reset-abort, same-cycle write and ignored commands.
module tb_cnn_stream_mem;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  localparam logic [ADDR_W:0] REG_CTRL   = 9'h100;
  localparam logic [ADDR_W:0] REG_BASE   = 9'h101;
  localparam logic [ADDR_W:0] REG_LEN    = 9'h102;
  localparam logic [ADDR_W:0] REG_STATUS = 9'h103;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W:0]   address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] val_out;
  logic              val_valid;
  logic [DATA_W-1:0] stream_data;
  logic              stream_valid;
  logic              stream_last;
  logic              stream_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model [DEPTH];

  typedef struct {
    logic            wr;
    logic [ADDR_W:0] addr;
    logic [15:0]     data;
    logic [15:0]     exp;
  } vec_t;
  vec_t vecs [13];

  cnn_stream_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata),
    .val_out(val_out), .val_valid(val_valid), .stream_data(stream_data),
    .stream_valid(stream_valid), .stream_last(stream_last),
    .stream_ready(stream_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W:0] a, input logic [15:0] exp, input string name);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    chk({name, " valid"}, {31'd0, val_valid}, 32'd1);
    chk(name, {16'd0, val_out}, {16'd0, exp});
  endtask

  // Called in the first CLEAR cycle: polls STATUS and counts busy cycles.
  task automatic clear_watch(input string tag);
    int busy_cnt = 0;
    int clr_cnt  = 0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = REG_STATUS;
    for (int i = 0; i < 260; i++) begin
      if (busy) busy_cnt++;
      tick();
      if (val_valid && val_out == 16'h0002) clr_cnt++;
    end
    chipselect = 1'b0; read = 1'b0;
    chk({tag, " busy cycles"}, busy_cnt, 32'd256);
    chk({tag, " clearing reads"}, clr_cnt, 32'd256);
    chk({tag, " final status"}, {16'd0, val_out}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) begin
      host_write(9'(i), 16'(16'h1000 + i));
      model[i] = 16'(16'h1000 + i);
    end
  endtask

  // Run one burst; ready_pct sets the stream_ready duty. With poke set, a LEN
  // write and a second START are issued while streaming (both must not disturb it).
  task automatic run_burst(input int base, input int len, input int ready_pct,
                           input bit poke, input string tag);
    logic [16:0] got[$];
    logic [16:0] held;
    logic [16:0] expv;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    bit r;
    int t = 1;
    int first_t = -1;
    int last_t = -1;
    int n;
    host_write(REG_BASE, 16'(base));
    host_write(REG_LEN, 16'(len));
    host_write(REG_CTRL, 16'h0001);
    chk({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    chk({tag, " no beat at N+1"}, {31'd0, stream_valid}, 32'd0);
    while (!fin && t < 3000) begin
      chipselect = 1'b0; write = 1'b0;
      if (poke && t == 2) begin
        chipselect = 1'b1; write = 1'b1; address = REG_LEN; writedata = 16'd3;
      end
      if (poke && t == 3) begin
        chipselect = 1'b1; write = 1'b1; address = REG_CTRL; writedata = 16'h0001;
      end
      if (stalled) begin
        chk({tag, " stall stability"}, {14'd0, stream_valid, stream_last, stream_data},
            {14'd0, 1'b1, held});
      end
      r = ($urandom_range(99) < ready_pct);
      stream_ready = r;
      if (stream_valid) begin
        if (first_t < 0) first_t = t;
        if (r) begin
          got.push_back({stream_last, stream_data});
          if (stream_last) begin
            fin = 1'b1;
            last_t = t;
          end
        end
      end
      stalled = stream_valid & ~r;
      held = {stream_last, stream_data};
      tick();
      t++;
    end
    stream_ready = 1'b0; chipselect = 1'b0; write = 1'b0;
    chk({tag, " completed"}, {31'd0, fin}, 32'd1);
    chk({tag, " busy after last"}, {31'd0, busy}, 32'd0);
    chk({tag, " valid after last"}, {31'd0, stream_valid}, 32'd0);
    chk({tag, " beat count"}, got.size(), len);
    n = (got.size() < len) ? got.size() : len;
    for (int i = 0; i < n; i++) begin
      expv = {(i == len - 1), model[(base + i) % DEPTH]};
      chk($sformatf("%s beat %0d", tag, i), {15'd0, got[i]}, {15'd0, expv});
    end
    if (ready_pct >= 100) begin
      chk({tag, " first beat cycle"}, first_t, 32'd2);
      chk({tag, " last beat cycle"}, last_t, 32'(1 + len));
    end
    host_read(REG_STATUS, 16'h0004, {tag, " done status"});
  endtask

  initial begin
    logic [15:0] old5;
    logic [15:0] old6;
    bit seen;
    int b;
    int l;

    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; stream_ready = 1'b0;
    repeat (3) tick();
    chk("reset val_out", {16'd0, val_out}, 32'd0);
    chk("reset val_valid", {31'd0, val_valid}, 32'd0);
    chk("reset stream", {14'd0, stream_valid, stream_last, stream_data}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    clear_watch("por clear");

    vecs[0]  = '{1'b0, 9'd0,       16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 9'd128,     16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 9'd255,     16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 9'd3,       16'hA5A5, 16'h0000};
    vecs[4]  = '{1'b0, 9'd3,       16'h0000, 16'hA5A5};
    vecs[5]  = '{1'b0, REG_BASE,   16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, REG_BASE,   16'h01FA, 16'h0000};
    vecs[7]  = '{1'b0, REG_BASE,   16'h0000, 16'h00FA};
    vecs[8]  = '{1'b1, REG_LEN,    16'h0300, 16'h0000};
    vecs[9]  = '{1'b0, REG_LEN,    16'h0000, 16'h0100};
    vecs[10] = '{1'b0, REG_CTRL,   16'h0000, 16'h0000};
    vecs[11] = '{1'b1, REG_STATUS, 16'hFFFF, 16'h0000};
    vecs[12] = '{1'b0, REG_STATUS, 16'h0000, 16'h0000};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].data);
      else host_read(vecs[i].addr, vecs[i].exp, $sformatf("vec %0d", i));
    end
    model[3] = 16'hA5A5;
    // val_valid is a single pulse and val_out holds afterwards.
    tick();
    chk("val_valid pulse end", {31'd0, val_valid}, 32'd0);
    host_read(9'd3, 16'hA5A5, "reread word 3");
    tick();
    chk("val_out hold", {16'd0, val_out}, 32'h0000A5A5);

    fill_ramp();
    run_burst(250, 10, 100, 1'b0, "wrap ready");
    run_burst(250, 10, 50, 1'b0, "wrap toggle");

    host_write(REG_CTRL, 16'h0004);
    host_read(REG_STATUS, 16'h0000, "ack clears done");
    host_write(REG_LEN, 16'h0000);
    host_write(REG_CTRL, 16'h0001);
    host_read(REG_STATUS, 16'h0004, "len0 done");
    seen = 1'b0;
    stream_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      seen |= stream_valid | busy;
      tick();
    end
    stream_ready = 1'b0;
    chk("len0 no beats", {31'd0, seen}, 32'd0);
    host_write(REG_CTRL, 16'h0004);
    host_read(REG_STATUS, 16'h0000, "len0 ack");

    run_burst(0, 10, 100, 1'b1, "start ignored");
    host_read(REG_LEN, 16'h0003, "len written mid burst");

    // Host writes racing the stream reads: same-cycle gets old data.
    old5 = model[5];
    old6 = model[6];
    host_write(REG_BASE, 16'd5);
    host_write(REG_LEN, 16'd3);
    host_write(REG_CTRL, 16'h0001);
    stream_ready = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 9'd5; writedata = 16'hBEEF;
    tick();
    chk("rbw beat0", {15'd0, stream_valid, stream_data}, {15'd0, 1'b1, old5});
    address = 9'd7; writedata = 16'hCAFE;
    tick();
    chk("rbw beat1", {15'd0, stream_valid, stream_data}, {15'd0, 1'b1, old6});
    writedata = 16'hD00D;
    tick();
    chipselect = 1'b0; write = 1'b0;
    chk("rbw beat2", {14'd0, stream_valid, stream_last, stream_data},
        {14'd0, 1'b1, 1'b1, 16'hCAFE});
    tick();
    stream_ready = 1'b0;
    model[5] = 16'hBEEF;
    model[7] = 16'hD00D;
    host_read(9'd5, 16'hBEEF, "rbw word5");
    host_read(9'd7, 16'hD00D, "rbw word7");

    run_burst(128, 256, 100, 1'b0, "full depth");
    run_burst(255, 1, 60, 1'b0, "single beat");
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 20; j++) begin
        b = $urandom_range(DEPTH - 1);
        model[b] = 16'($urandom);
        host_write(9'(b), model[b]);
      end
      b = $urandom_range(DEPTH - 1);
      l = $urandom_range(DEPTH, 1);
      run_burst(b, l, $urandom_range(90, 30), 1'b0, $sformatf("random %0d", k));
    end

    // START and CLEAR together: CLEAR wins.
    host_write(REG_CTRL, 16'h0003);
    clear_watch("cmd clear");
    host_read(9'd3, 16'h0000, "cmd clear word3");
    host_read(9'd200, 16'h0000, "cmd clear word200");

    // Reset while beat 4 of 10 is on the port.
    fill_ramp();
    host_write(REG_BASE, 16'd250);
    host_write(REG_LEN, 16'd10);
    host_write(REG_CTRL, 16'h0001);
    stream_ready = 1'b1;
    repeat (4) tick();
    chk("abort beat4", {15'd0, stream_valid, stream_data}, {15'd0, 1'b1, model[253]});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stream_ready = 1'b0;
    chk("abort valid drop", {31'd0, stream_valid}, 32'd0);
    clear_watch("abort clear");
    for (int i = 0; i < DEPTH; i++) begin
      host_read(9'(i), model[i], $sformatf("abort word %0d", i));
    end
    host_read(REG_BASE, 16'h0000, "abort base");
    host_read(REG_LEN, 16'h0000, "abort len");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnn_stream_mem.md
# cnn_stream_mem

Parametrised on-chip memory for the CNN accelerator. It is the next generation of the host-written weight/image RAM. The host accesses it through a chipselect/read/write register port, and a stream engine bursts a contiguous, wrap-around range of words to the compute datapath over a valid/ready port. A multi-cycle sequential clear engine replaces the single-cycle array reset.

## Interface
- DATA_W, 16, word width; multiple of 8, at least 8
- DEPTH, 256, number of words; power of two, at least 4
- ADDR_W, $clog2(DEPTH), RAM index width; derived, not overridden
- clk  input  1  single clock; all logic rising-edge
- reset  input  1  synchronous, active-high
- chipselect  input  1  host access qualifier
- write  input  1  host write strobe (with chipselect)
- read  input  1  host read strobe (with chipselect)
- address  input  ADDR_W+1  MSB=0: RAM word [ADDR_W-1:0]; MSB=1: control register [1:0]
- writedata  input  DATA_W  host write data
- val_out  output  DATA_W  host read data, registered
- val_valid  output  1  one-cycle pulse, val_out updated this cycle
- stream_data  output  DATA_W  stream beat data
- stream_valid  output  1  beat present
- stream_last  output  1  final beat of burst, qualified by stream_valid
- stream_ready  input  1  consumer accepts beat when high with stream_valid
- busy  output  1  FSM not in IDLE

## Operation
- Control registers (address MSB=1):
  - 0 CTRL (write-only; bits self-clear): bit0 START, bit1 CLEAR, bit2 DONE_ACK
  - 1 BASE: start index; low ADDR_W bits used
  - 2 LEN: beat count; low ADDR_W+1 bits used, max DEPTH
  - 3 STATUS (read-only): bit0 streaming, bit1 clearing, bit2 done (sticky)
- Reads of CTRL return 0. Writes to STATUS are ignored.
- FSM states: CLEAR, IDLE, STREAM, DRAIN.
  - Reset enters CLEAR. Reset mid-operation aborts any burst, empties the skid buffer and restarts CLEAR.
  - CLEAR: writes 0 to word k, k = 0..DEPTH-1, one word per cycle. Enters IDLE after word DEPTH-1.
  - IDLE + START, LEN>0: enter STREAM, clear done.
  - IDLE + START, LEN=0: set done next cycle, no beats.
  - IDLE + CLEAR: enter CLEAR, clear done.
  - STREAM: issue RAM reads at index (BASE+i) mod DEPTH, i = 0..LEN-1. Enter DRAIN once all LEN reads are issued.
  - DRAIN: when the last beat is accepted, set done and enter IDLE.
- START or CLEAR outside IDLE is ignored. The same-cycle BASE/LEN write takes effect only for the next START.
- DONE_ACK clears done. If DONE_ACK coincides with done being set, the set wins.
- START and CLEAR in the same CTRL write: CLEAR wins.
- Host RAM writes:
  - Accepted in IDLE, STREAM and DRAIN.
  - Dropped during CLEAR.
  - Same-cycle conflict with a stream read of the same index: the stream gets the old data (read-before-write).
- Host RAM reads are allowed in every state. During CLEAR they return current contents.
- Stream buffer:
  - 2-entry skid buffer after the 1-cycle RAM read.
  - A read is issued only if a buffer slot will be free when the data returns.
  - No beat is lost or duplicated under any stream_ready pattern.
- stream_data, stream_valid and stream_last stay stable while stream_valid=1 and stream_ready=0.

## Timing
- Reset values: val_out=0, val_valid=0, stream_valid=0, stream_last=0, stream_data=0, busy=1 (CLEAR).
  - Registers: BASE=0, LEN=0, done=0.
- CLEAR lasts exactly DEPTH cycles after reset deassertion or the CLEAR write. busy falls the cycle after.
- Host read: strobe in cycle N → val_out valid and val_valid=1 in N+1. val_out holds its value until the next read.
- Host write: RAM updated at the edge ending the strobe cycle. A read in the next cycle sees the new data.
- Stream timing with the START write in cycle N:
  - State is STREAM in N+1, and the first read is issued in N+1.
  - First stream_valid is in N+2.
  - With stream_ready held at 1, there is one beat per cycle, and the last beat is in N+1+LEN.
- done is set (STATUS bit2, busy=0) in the cycle after the last beat is accepted.
- If the last beat is accepted in cycle M, START can first be accepted in M+1.
- Wrap-around: index DEPTH-1 is followed by 0 within a burst. LEN=DEPTH streams every word once.

## Test plan
- Reset then poll STATUS → clearing=1 for 256 cycles, then STATUS=0. Reading RAM words 0, 128, 255 → 0x0000.
- Write 0xA5A5 to word 3, read word 3 next cycle → val_out=0xA5A5 with val_valid one cycle after the read strobe.
- Fill words i=0..255 with 0x1000+i, BASE=250, LEN=10, START, stream_ready=1:
  - beats 0x10FA..0x10FF, then 0x1000..0x1003
  - stream_last on the 10th beat
  - done set, busy=0
- Same burst with stream_ready toggled pseudo-randomly → identical 10-beat sequence, data stable while stalled.
- Write LEN=0 and START → no stream_valid, done=1. DONE_ACK → done=0. START while streaming → ignored, burst length unchanged.
- Mid-burst (beat 4 of 10) assert reset for one cycle:
  - stream_valid=0 the next cycle
  - CLEAR runs 256 cycles
  - all words read back 0
